// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: processor, accelerator and dmem signals shared through the arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p_req;
    logic              p_wren;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_ack;
    logic [DATA_W-1:0] p_rdata;
    logic              p_rvalid;
    logic              a_req;
    logic              a_wren;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;
    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;

    modport slave (
        input  p_req, p_wren, p_addr, p_wdata, a_req, a_wren, a_addr, a_wdata, q_dmem,
        output p_ack, p_rdata, p_rvalid, a_ack, a_rdata, a_rvalid, address_dmem, data, wren
    );

    modport master (
        output p_req, p_wren, p_addr, p_wdata, a_req, a_wren, a_addr, a_wdata, q_dmem,
        input  p_ack, p_rdata, p_rvalid, a_ack, a_rdata, a_rvalid, address_dmem, data, wren
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between processor (P) and accelerator (A).
// Define DMEM_ARB_ROUND_ROBIN_EN to break IDLE ties toward the side that did not own last.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input logic          clock,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN_P, OWN_A} state_t;

    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rd_pend_p_q, rd_pend_p_d;
    logic          rd_pend_a_q, rd_pend_a_d;
    logic          own_p, own_a, p_ack, a_ack, hold_hit, tie_p;

    assign own_p    = state_q == OWN_P;
    assign own_a    = state_q == OWN_A;
    assign p_ack    = own_p & bus.p_req;
    assign a_ack    = own_a & bus.a_req;
    assign hold_hit = hold_q == HOLD_MAX;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;  // 1 = A owned last

    assign tie_p = last_owner_q;

    always_comb begin
        last_owner_d = (state_d == OWN_P && !own_p) ? 1'b0 :
                       (state_d == OWN_A && !own_a) ? 1'b1 : last_owner_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_owner_q <= 1'b1;
        else       last_owner_q <= last_owner_d;
    end
`else
    assign tie_p = 1'b1;
`endif

    assign bus.p_ack        = p_ack;
    assign bus.a_ack        = a_ack;
    assign bus.address_dmem = own_p ? bus.p_addr : own_a ? bus.a_addr : '0;
    assign bus.data         = own_p ? bus.p_wdata : own_a ? bus.a_wdata : '0;
    assign bus.wren         = (p_ack & bus.p_wren) | (a_ack & bus.a_wren);
    assign bus.p_rdata      = bus.q_dmem;
    assign bus.a_rdata      = bus.q_dmem;
    assign bus.p_rvalid     = rd_pend_p_q;
    assign bus.a_rvalid     = rd_pend_a_q;

    always_comb begin
        state_d = own_p ? (!bus.p_req ? (bus.a_req ? OWN_A : IDLE) :
                           (hold_hit && bus.a_req) ? OWN_A : OWN_P) :
                  own_a ? (!bus.a_req ? (bus.p_req ? OWN_P : IDLE) :
                           (hold_hit && bus.p_req) ? OWN_P : OWN_A) :
                  bus.p_req ? ((bus.a_req && !tie_p) ? OWN_A : OWN_P) :
                  bus.a_req ? OWN_A : IDLE;
        // Counter saturates while the other side stays quiet.
        hold_d = (state_d != state_q || state_d == IDLE) ? '0 :
                 ((p_ack || a_ack) && !hold_hit) ? hold_q + HW'(1) : hold_q;
        rd_pend_p_d = p_ack & ~bus.p_wren;
        rd_pend_a_d = a_ack & ~bus.a_wren;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            rd_pend_p_q <= 1'b0;
            rd_pend_a_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            rd_pend_p_q <= rd_pend_p_d;
            rd_pend_a_q <= rd_pend_a_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: grant table plus hand-written streaming, hold, interleave and reset sequences.
// Read data is checked by a scoreboard queue per side against a behavioural dmem.
module tb_dmem_arbiter;
    typedef struct {
        logic p;
        logic a;
        logic ep;
        logic ea;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem [0:1023];
    logic [31:0] q;
    logic [31:0] pq [$];
    logic [31:0] aq [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    vec_t        tv [5];
    int          tr [12];
    int          ex_tr [12] = '{0, 2, 2, 2, 2, 1, 0, 2, 2, 2, 2, 0};

    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always @(posedge clock) begin
        if (bus.wren) mem[bus.address_dmem[9:0]] <= bus.data;
        q <= mem[bus.address_dmem[9:0]];
    end
    assign bus.q_dmem = q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            chk("single_ack", 32'(bus.p_ack & bus.a_ack), 32'd0);
            if (bus.p_rvalid) begin
                if (pq.size() == 0) chk("p_rvalid_unexpected", 32'(bus.p_rvalid), 32'd0);
                else chk("p_rdata", bus.p_rdata, pq.pop_front());
            end
            if (bus.a_rvalid) begin
                if (aq.size() == 0) chk("a_rvalid_unexpected", 32'(bus.a_rvalid), 32'd0);
                else chk("a_rdata", bus.a_rdata, aq.pop_front());
            end
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    // One complete access by one side; lat counts cycles from request to ack.
    task automatic acc(input bit a_side, input bit wr, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] ex, output int lat);
        logic ack;
        if (a_side) begin
            bus.a_req = 1'b1; bus.a_wren = wr; bus.a_addr = ad; bus.a_wdata = wd;
        end else begin
            bus.p_req = 1'b1; bus.p_wren = wr; bus.p_addr = ad; bus.p_wdata = wd;
        end
        lat = 0;
        @(negedge clock);
        ack = a_side ? bus.a_ack : bus.p_ack;
        while (!ack && lat < 20) begin
            nxt();
            lat++;
            @(negedge clock);
            ack = a_side ? bus.a_ack : bus.p_ack;
        end
        chk("acc_granted", 32'(ack), 32'd1);
        if (ack) begin
            chk("acc_other_ack", 32'(a_side ? bus.p_ack : bus.a_ack), 32'd0);
            chk("acc_addr", bus.address_dmem, ad);
            chk("acc_wren", 32'(bus.wren), 32'(wr));
            if (wr) chk("acc_data", bus.data, wd);
            else if (a_side) aq.push_back(ex);
            else pq.push_back(ex);
        end
        nxt();
        if (a_side) bus.a_req = 1'b0;
        else bus.p_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, idx, na, np;
        reset = 1'b1;
        bus.p_req = 1'b0; bus.p_wren = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.a_req = 1'b0; bus.a_wren = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h10] = 32'hDEADBEEF;
        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tv[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        tv[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_p_ack", 32'(bus.p_ack), 32'd0);
        chk("rst_a_ack", 32'(bus.a_ack), 32'd0);
        chk("rst_p_rvalid", 32'(bus.p_rvalid), 32'd0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("rst_wren", 32'(bus.wren), 32'd0);
        chk("rst_addr", bus.address_dmem, 32'd0);
        chk("rst_data", bus.data, 32'd0);
        nxt();
        reset = 1'b0;

        // Processor-only read
        acc(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, lat);
        chk("p_read_lat", 32'(lat), 32'd1);
        @(negedge clock);
        nxt();

        // Grant table from IDLE
        for (int i = 0; i < 5; i++) begin
            bus.p_req = tv[i].p; bus.p_wren = 1'b1; bus.p_addr = 32'h200; bus.p_wdata = 32'(32'h1000 + i);
            bus.a_req = tv[i].a; bus.a_wren = 1'b1; bus.a_addr = 32'h204; bus.a_wdata = 32'(32'h2000 + i);
            @(negedge clock);
            chk("idle_no_ack", 32'({bus.p_ack, bus.a_ack}), 32'd0);
            nxt();
            @(negedge clock);
            chk("grant_p", 32'(bus.p_ack), 32'(tv[i].ep));
            chk("grant_a", 32'(bus.a_ack), 32'(tv[i].ea));
            chk("grant_addr", bus.address_dmem, tv[i].ep ? 32'h200 : tv[i].ea ? 32'h204 : 32'h0);
            nxt();
            bus.p_req = 1'b0;
            bus.a_req = 1'b0;
            @(negedge clock);
            nxt();
        end

        // Accelerator streaming, processor cuts in after the second write
        idx = 0;
        bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_addr = 32'h100; bus.a_wdata = 32'hA0000000;
        bus.p_wren = 1'b0; bus.p_addr = 32'h10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            tr[c] = bus.a_ack ? 2 : bus.p_ack ? 1 : 0;
            if (bus.a_ack) chk("stream_addr", bus.address_dmem, 32'(32'h100 + idx));
            if (bus.p_ack) begin
                chk("stream_p_addr", bus.address_dmem, 32'h10);
                pq.push_back(32'hDEADBEEF);
            end
            nxt();
            if (tr[c] == 2) begin
                idx++;
                if (idx == 8) bus.a_req = 1'b0;
                bus.a_addr = 32'(32'h100 + idx);
                bus.a_wdata = 32'(32'hA0000000 + idx);
                if (idx == 2) bus.p_req = 1'b1;
            end
            if (tr[c] == 1) bus.p_req = 1'b0;
        end
        for (int c = 0; c < 12; c++) chk("stream_trace", 32'(tr[c]), 32'(ex_tr[c]));
        chk("stream_mem_first", mem[10'h100], 32'hA0000000);
        chk("stream_mem_last", mem[10'h107], 32'hA0000007);

        // Saturated hold: long solo run still yields right after one more access
        na = 0;
        np = -1;
        bus.a_req = 1'b1; bus.a_addr = 32'h140; bus.a_wdata = 32'hB0000000;
        for (int c = 0; c < 20 && np < 0; c++) begin
            @(negedge clock);
            if (bus.p_ack) begin
                np = na;
                pq.push_back(32'hDEADBEEF);
            end
            if (bus.a_ack) na++;
            nxt();
            bus.a_addr = 32'(32'h140 + na);
            bus.a_wdata = 32'(32'hB0000000 + na);
            if (na >= 6) bus.p_req = 1'b1;
            if (np >= 0) begin
                bus.p_req = 1'b0;
                bus.a_req = 1'b0;
            end
        end
        chk("sat_a_acks_before_p", 32'(np), 32'd7);
        @(negedge clock);
        nxt();

        // Processor write then accelerator read of the same word
        acc(1'b0, 1'b1, 32'h20, 32'h55, 32'h0, lat);
        acc(1'b1, 1'b0, 32'h20, 32'h0, 32'h55, lat);
        chk("switch_lat", 32'(lat), 32'd1);
        @(negedge clock);
        nxt();

        // Reset during a processor read ack cycle
        bus.p_req = 1'b1; bus.p_wren = 1'b0; bus.p_addr = 32'h10;
        @(negedge clock);
        nxt();
        @(negedge clock);
        chk("rr_pre_ack", 32'(bus.p_ack), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rr_p_ack", 32'(bus.p_ack), 32'd0);
        chk("rr_p_rvalid", 32'(bus.p_rvalid), 32'd0);
        chk("rr_wren", 32'(bus.wren), 32'd0);
        chk("rr_addr", bus.address_dmem, 32'd0);
        bus.p_req = 1'b0;
        nxt();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            nxt();
        end
        acc(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, lat);
        chk("post_reset_lat", 32'(lat), 32'd1);
        @(negedge clock);
        nxt();

        chk("pq_drained", 32'(pq.size()), 32'd0);
        chk("aq_drained", 32'(aq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
